// File: rtl/instr_sequencer.sv
// instr_sequencer -- multi-cycle instruction sequencer for a simple RV32-style
// datapath. Walks IDLE -> FETCH -> DECODE -> EXECUTE -> [MEMORY] -> [WRITEBACK]
// and retires, with a sticky FAULT state for illegal opcodes and memory timeouts.
//
// Parameters:
//   DATA_WIDTH   width of the retired-instruction counter
//   MEM_WAIT_MAX consecutive mem_ready=0 cycles tolerated in FETCH/MEMORY (0 = no limit)
//
// Optional build macro:
//   INSTR_SEQ_PERF_CNT_EN  builds the retired-instruction counter; otherwise
//                          instr_count is tied to 0.
//
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   start, halt_req     begin fetching from IDLE / stop after the retiring instruction
//   opcode[6:0]         instruction[6:0], valid from DECODE onward
//   mem_ready           memory completes the current access this cycle
//   ir_write, pc_write, regwrite, memread, memwrite, memtoreg   datapath strobes
//   busy, fault, state  status and encoded state
//   instr_count         retired-instruction count
module instr_sequencer #(
  parameter int unsigned DATA_WIDTH   = 32,
  parameter int unsigned MEM_WAIT_MAX = 15
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  halt_req,
  input  logic [6:0]            opcode,
  input  logic                  mem_ready,
  output logic                  ir_write,
  output logic                  pc_write,
  output logic                  regwrite,
  output logic                  memread,
  output logic                  memwrite,
  output logic                  memtoreg,
  output logic                  busy,
  output logic                  fault,
  output logic [2:0]            state,
  output logic [DATA_WIDTH-1:0] instr_count
);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_FETCH     = 3'd1,
    S_DECODE    = 3'd2,
    S_EXECUTE   = 3'd3,
    S_MEMORY    = 3'd4,
    S_WRITEBACK = 3'd5,
    S_FAULT     = 3'd6
  } state_e;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;

  localparam int unsigned WAIT_W = (MEM_WAIT_MAX < 2) ? 1 : $clog2(MEM_WAIT_MAX + 1);
  // Value of the wait count on the last tolerated cycle; a further miss faults.
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MEM_WAIT_MAX - 1);

  state_e            state_q, state_d;
  logic [WAIT_W-1:0] wait_cnt_q, wait_cnt_d;

  logic is_load, is_store, is_branch, is_legal;
  logic retire, mem_wait;
  logic ir_write_raw, regwrite_raw, memread_raw, memwrite_raw, memtoreg_raw;

  always_comb begin
    is_load   = (opcode == OP_LOAD);
    is_store  = (opcode == OP_STORE);
    is_branch = (opcode == OP_BRANCH);
    is_legal  = (opcode inside {OP_R, OP_I, OP_LOAD, OP_STORE, OP_BRANCH,
                                OP_JAL, OP_JALR, OP_LUI, OP_AUIPC});
  end

  always_comb begin
    state_d      = state_q;
    wait_cnt_d   = wait_cnt_q;
    retire       = 1'b0;
    mem_wait     = 1'b0;
    ir_write_raw = 1'b0;
    regwrite_raw = 1'b0;
    memread_raw  = 1'b0;
    memwrite_raw = 1'b0;
    memtoreg_raw = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (start) state_d = S_FETCH;
      end
      S_FETCH: begin
        memread_raw = 1'b1;
        if (mem_ready) begin
          ir_write_raw = 1'b1;
          state_d      = S_DECODE;
        end else begin
          mem_wait = 1'b1;
        end
      end
      S_DECODE: begin
        state_d = is_legal ? S_EXECUTE : S_FAULT;
      end
      S_EXECUTE: begin
        if (is_load || is_store) state_d = S_MEMORY;
        else if (is_branch)      retire  = 1'b1;
        else                     state_d = S_WRITEBACK;
      end
      S_MEMORY: begin
        memread_raw  = is_load;
        memwrite_raw = !is_load;
        if (mem_ready) begin
          if (is_load) state_d = S_WRITEBACK;
          else         retire  = 1'b1;
        end else begin
          mem_wait = 1'b1;
        end
      end
      S_WRITEBACK: begin
        regwrite_raw = 1'b1;
        memtoreg_raw = is_load;
        retire       = 1'b1;
      end
      S_FAULT: begin
        state_d = S_FAULT;
      end
      default: begin
        state_d = S_FAULT;
      end
    endcase

    if (retire) state_d = halt_req ? S_IDLE : S_FETCH;

    // A completed access (mem_ready=1) never reaches this branch, so a ready
    // arriving on the last tolerated cycle wins over the timeout.
    if (mem_wait) begin
      wait_cnt_d = wait_cnt_q + 1'b1;
      if ((MEM_WAIT_MAX != 0) && (wait_cnt_q == WAIT_LAST)) state_d = S_FAULT;
    end

    if (state_d != state_q) wait_cnt_d = '0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      wait_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
    end
  end

  // Outputs are forced quiet while rst is high, even before the reset edge.
  always_comb begin
    ir_write = ir_write_raw & ~rst;
    pc_write = retire       & ~rst;
    regwrite = regwrite_raw & ~rst;
    memread  = memread_raw  & ~rst;
    memwrite = memwrite_raw & ~rst;
    memtoreg = memtoreg_raw & ~rst;
    busy     = ~rst & (state_q != S_IDLE) & (state_q != S_FAULT);
    fault    = ~rst & (state_q == S_FAULT);
    state    = rst ? 3'd0 : state_q;
  end

`ifdef INSTR_SEQ_PERF_CNT_EN
  logic [DATA_WIDTH-1:0] instr_count_q, instr_count_d;

  always_comb begin
    instr_count_d = instr_count_q;
    if (retire) instr_count_d = instr_count_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) instr_count_q <= '0;
    else     instr_count_q <= instr_count_d;
  end

  assign instr_count = instr_count_q;
`else
  assign instr_count = '0;
`endif

endmodule

// File: tb/tb_instr_sequencer.sv
// Directed testbench for instr_sequencer. Each step drives one cycle of
// inputs, pushes the expected outputs for that cycle into a scoreboard queue
// and pops/compares them on the falling edge.
module tb_instr_sequencer;

  localparam int unsigned DW = 32;

  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_LD  = 7'b0000011;
  localparam logic [6:0] OP_ST  = 7'b0100011;
  localparam logic [6:0] OP_BR  = 7'b1100011;
  localparam logic [6:0] OP_LUI = 7'b0110111;
  localparam logic [6:0] OP_BAD = 7'b1111111;

  // Strobe vector order: {ir_write, pc_write, regwrite, memread, memwrite, memtoreg}
  localparam logic [5:0] S_NONE   = 6'b000000;
  localparam logic [5:0] S_MR     = 6'b000100;
  localparam logic [5:0] S_IRW    = 6'b100100;
  localparam logic [5:0] S_WB_RET = 6'b011000;
  localparam logic [5:0] S_LD_WB  = 6'b011001;
  localparam logic [5:0] S_MW     = 6'b000010;
  localparam logic [5:0] S_ST_RET = 6'b010010;
  localparam logic [5:0] S_BR_RET = 6'b010000;

  logic clk = 1'b0;
  logic rst = 1'b1, start = 1'b0, halt_req = 1'b0, mem_ready = 1'b0;
  logic [6:0] opcode = OP_R;
  logic ir_write, pc_write, regwrite, memread, memwrite, memtoreg, busy, fault;
  logic [2:0] state;
  logic [DW-1:0] instr_count;

  always #5 clk = ~clk;

  instr_sequencer #(.DATA_WIDTH(DW), .MEM_WAIT_MAX(15)) dut (
    .clk(clk), .rst(rst), .start(start), .halt_req(halt_req), .opcode(opcode),
    .mem_ready(mem_ready), .ir_write(ir_write), .pc_write(pc_write),
    .regwrite(regwrite), .memread(memread), .memwrite(memwrite),
    .memtoreg(memtoreg), .busy(busy), .fault(fault), .state(state),
    .instr_count(instr_count)
  );

  typedef struct {
    string       tag;
    logic [2:0]  st;
    logic [5:0]  strb;
    logic        busy;
    logic        fault;
    logic [DW-1:0] cnt;
  } exp_t;

  exp_t sb[$];
  int unsigned checks = 0;
  int unsigned errors = 0;
  logic [DW-1:0] exp_cnt = '0;

  task automatic chk(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step(input string tag, input logic r, input logic s, input logic h,
                      input logic [6:0] op, input logic mr,
                      input logic [2:0] es, input logic [5:0] estr);
    exp_t e;
    exp_t g;
    @(posedge clk);
    #1;
    rst = r; start = s; halt_req = h; opcode = op; mem_ready = mr;
    e.tag   = tag;
    e.st    = es;
    e.strb  = estr;
    e.busy  = (es >= 3'd1) && (es <= 3'd5);
    e.fault = (es == 3'd6);
    e.cnt   = exp_cnt;
    sb.push_back(e);
    if (r) exp_cnt = '0;
`ifdef INSTR_SEQ_PERF_CNT_EN
    else if (estr[4]) exp_cnt = exp_cnt + 1'b1;
`endif
    @(negedge clk);
    if (sb.size() == 0) begin
      checks++;
      errors++;
      $error("FAIL %s: scoreboard empty", tag);
    end else begin
      g = sb.pop_front();
      chk({g.tag, ".state"}, DW'(state), DW'(g.st));
      chk({g.tag, ".strobes"},
          DW'({ir_write, pc_write, regwrite, memread, memwrite, memtoreg}), DW'(g.strb));
      chk({g.tag, ".busy"}, DW'(busy), DW'(g.busy));
      chk({g.tag, ".fault"}, DW'(fault), DW'(g.fault));
      chk({g.tag, ".count"}, instr_count, g.cnt);
    end
  endtask

  initial begin
    // R-type with mem_ready high: 4-cycle latency, retire in WRITEBACK
    step("reset",      1, 0, 0, OP_R, 0, 3'd0, S_NONE);
    step("idle_start", 0, 1, 0, OP_R, 0, 3'd0, S_NONE);
    step("r_fetch",    0, 0, 0, OP_R, 1, 3'd1, S_IRW);
    step("r_dec",      0, 0, 0, OP_R, 1, 3'd2, S_NONE);
    step("r_exe_halt", 0, 0, 1, OP_R, 1, 3'd3, S_NONE);
    step("r_wb",       0, 0, 0, OP_R, 1, 3'd5, S_WB_RET);
    // Branch: retire in EXECUTE
    step("br_fetch",   0, 0, 0, OP_BR, 1, 3'd1, S_IRW);
    step("br_dec",     0, 0, 0, OP_BR, 1, 3'd2, S_NONE);
    step("br_exe",     0, 0, 0, OP_BR, 1, 3'd3, S_BR_RET);
    // Load with three MEMORY wait cycles, halt at retire
    step("ld_fetch",   0, 0, 0, OP_LD, 1, 3'd1, S_IRW);
    step("ld_dec",     0, 0, 0, OP_LD, 1, 3'd2, S_NONE);
    step("ld_exe",     0, 0, 0, OP_LD, 1, 3'd3, S_NONE);
    for (int i = 0; i < 3; i++)
      step("ld_mem_wait", 0, 0, 0, OP_LD, 0, 3'd4, S_MR);
    step("ld_mem_done", 0, 0, 0, OP_LD, 1, 3'd4, S_MR);
    step("ld_wb",       0, 0, 1, OP_LD, 1, 3'd5, S_LD_WB);
    step("idle_halt",   0, 0, 1, OP_LD, 1, 3'd0, S_NONE);
    step("idle_start2", 0, 1, 0, OP_ST, 1, 3'd0, S_NONE);
    // Store retiring in MEMORY with halt
    step("st_fetch",   0, 0, 0, OP_ST, 1, 3'd1, S_IRW);
    step("st_dec",     0, 1, 0, OP_ST, 1, 3'd2, S_NONE);
    step("st_exe",     0, 0, 0, OP_ST, 1, 3'd3, S_NONE);
    step("st_mem",     0, 0, 1, OP_ST, 1, 3'd4, S_ST_RET);
    step("st_idle",    0, 0, 0, OP_ST, 1, 3'd0, S_NONE);
    // Reset in the middle of a store access
    step("st2_start",  0, 1, 0, OP_ST, 1, 3'd0, S_NONE);
    step("st2_fetch",  0, 0, 0, OP_ST, 1, 3'd1, S_IRW);
    step("st2_dec",    0, 0, 0, OP_ST, 1, 3'd2, S_NONE);
    step("st2_exe",    0, 0, 0, OP_ST, 1, 3'd3, S_NONE);
    step("st2_mem",    0, 0, 0, OP_ST, 0, 3'd4, S_MW);
    step("st2_rst",    1, 0, 0, OP_ST, 0, 3'd0, S_NONE);
    step("st2_post",   0, 0, 0, OP_ST, 0, 3'd0, S_NONE);
    // Illegal opcode -> sticky FAULT
    step("f_start",    0, 1, 0, OP_BAD, 1, 3'd0, S_NONE);
    step("f_fetch",    0, 0, 0, OP_BAD, 1, 3'd1, S_IRW);
    step("f_dec",      0, 0, 0, OP_BAD, 1, 3'd2, S_NONE);
    step("f_start_ig", 0, 1, 0, OP_R,   1, 3'd6, S_NONE);
    step("f_halt_ig",  0, 0, 1, OP_R,   1, 3'd6, S_NONE);
    step("f_rst",      1, 0, 0, OP_R,   1, 3'd0, S_NONE);
    step("f_idle",     0, 0, 0, OP_R,   1, 3'd0, S_NONE);
    // FETCH timeout after exactly 15 wait cycles
    step("to_start",   0, 1, 0, OP_R, 0, 3'd0, S_NONE);
    for (int i = 0; i < 15; i++)
      step("to_wait", 0, 0, 0, OP_R, 0, 3'd1, S_MR);
    step("to_fault",   0, 0, 0, OP_R, 0, 3'd6, S_NONE);
    step("to_rst",     1, 0, 0, OP_R, 0, 3'd0, S_NONE);
    // Ready on the 15th cycle completes the fetch
    step("ok_start",   0, 1, 0, OP_LUI, 0, 3'd0, S_NONE);
    for (int i = 0; i < 14; i++)
      step("ok_wait", 0, 0, 0, OP_LUI, 0, 3'd1, S_MR);
    step("ok_ready",   0, 0, 0, OP_LUI, 1, 3'd1, S_IRW);
    step("ok_dec",     0, 0, 0, OP_LUI, 1, 3'd2, S_NONE);
    step("ok_exe",     0, 0, 0, OP_LUI, 1, 3'd3, S_NONE);
    step("ok_wb",      0, 0, 1, OP_LUI, 1, 3'd5, S_WB_RET);
    step("ok_idle",    0, 0, 0, OP_LUI, 1, 3'd0, S_NONE);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/instr_sequencer.md
INSTR_SEQUENCER -- requirements
Module: instr_sequencer

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, width of the retired-instruction counter.
REQ-002 SHALL have parameter MEM_WAIT_MAX, default 15, max consecutive memory wait cycles; 0 disables the timeout.
REQ-003 SHALL have port clk  input  1  single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-005 SHALL have port start  input  1  leave IDLE and begin fetching.
REQ-006 SHALL have port halt_req  input  1  stop after the current instruction retires.
REQ-007 SHALL have port opcode  input  7  instruction[6:0] from the instruction register; valid from DECODE onward.
REQ-008 SHALL have port mem_ready  input  1  memory completes the current read/write this cycle.
REQ-009 SHALL have ports ir_write, pc_write, regwrite, memread, memwrite, memtoreg  output  1 each  datapath strobes.
REQ-010 SHALL have ports busy  output  1, fault  output  1, state  output  3  status and encoded state.
REQ-011 SHALL have port instr_count  output  DATA_WIDTH  retired-instruction count.

Function
REQ-012 SHALL implement states IDLE=0, FETCH=1, DECODE=2, EXECUTE=3, MEMORY=4, WRITEBACK=5, FAULT=6; state output equals the current encoding.
REQ-013 SHALL drive all strobes combinationally from the registered state, opcode and mem_ready; every strobe is 0 unless a rule below asserts it.
REQ-014 IDLE: start=1 -> FETCH; otherwise remain.
REQ-015 FETCH: memread=1; mem_ready=1 -> ir_write=1 and go to DECODE; otherwise remain.
REQ-016 DECODE: one cycle; legal opcode (0110011, 0010011, 0000011, 0100011, 1100011, 1101111, 1100111, 0110111, 0010111) -> EXECUTE; any other value -> FAULT.
REQ-017 EXECUTE: one cycle; load 0000011 or store 0100011 -> MEMORY; branch 1100011 -> retire; all other opcodes -> WRITEBACK.
REQ-018 MEMORY: load -> memread=1; store -> memwrite=1; hold until mem_ready=1; then load -> WRITEBACK, store -> retire.
REQ-019 WRITEBACK: regwrite=1; memtoreg=1 only for load; then retire.
REQ-020 Retire cycle: pc_write=1 for exactly this one cycle; next state is IDLE if halt_req=1 in this cycle, else FETCH.
REQ-021 Cycle latency with mem_ready held high: R/I/JAL/JALR/LUI/AUIPC 4, load 5, store 4, branch 3 (FETCH entry to retire, inclusive).
REQ-022 Timeout: count consecutive cycles with mem_ready=0 in FETCH or MEMORY; the count clears on each state entry; when the count reaches MEM_WAIT_MAX (non-zero) -> FAULT on the next edge.
REQ-023 mem_ready=1 in the same cycle the count reaches its limit SHALL complete the access normally; no fault.
REQ-024 FAULT: sticky until rst; fault=1, all strobes 0, start and halt_req ignored.
REQ-025 busy=1 in every state except IDLE and FAULT.
REQ-026 halt_req outside a retire cycle SHALL have no effect; start outside IDLE SHALL be ignored.

Reset
REQ-027 rst=1 at a clock edge SHALL force state IDLE, wait count 0 and instr_count 0, regardless of current state, including mid-access.
REQ-028 While in reset: all strobes 0, busy=0, fault=0, state=0.

Configuration
REQ-029 With macro INSTR_SEQ_PERF_CNT_EN defined, instr_count SHALL increment by 1 on every retire cycle and wrap from 2^DATA_WIDTH-1 to 0.
REQ-030 Without INSTR_SEQ_PERF_CNT_EN, instr_count SHALL be constant 0 and no counter register is built; all other behaviour is unchanged.

Verification
REQ-031 rst, start=1 for one cycle, opcode=0110011, mem_ready=1 -> FETCH, DECODE, EXECUTE, WRITEBACK; regwrite=1 and pc_write=1 in cycle 4; instr_count=1 (macro on).
REQ-032 Load 0000011 with mem_ready low for 3 MEMORY cycles -> memread held for 4 cycles; then WRITEBACK with memtoreg=1, regwrite=1, pc_write=1.
REQ-033 opcode=1111111 at DECODE -> FAULT next cycle, fault=1, busy=0; start=1 has no effect; rst returns state=0.
REQ-034 MEM_WAIT_MAX=15, mem_ready=0 in FETCH -> FAULT after exactly 15 wait cycles; repeat with mem_ready=1 on the 15th cycle -> DECODE, no fault.
REQ-035 Store 0100011 with halt_req=1 on the retire cycle -> memwrite=1, pc_write=1, then IDLE, busy=0; rst asserted mid-MEMORY -> IDLE, all strobes 0.
